// File: rtl/tmds_pkg.sv
// Shared constants, types and decode helpers for the multi-channel TMDS decoder.
package tmds_pkg;

    localparam int unsigned WORD_W  = 10;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CTRL_W  = 2;
    localparam int unsigned TERC4_W = 4;

    localparam logic [WORD_W-1:0] CTRL_TOK_00 = 10'b1101010100;
    localparam logic [WORD_W-1:0] CTRL_TOK_01 = 10'b0010101011;
    localparam logic [WORD_W-1:0] CTRL_TOK_10 = 10'b0101010100;
    localparam logic [WORD_W-1:0] CTRL_TOK_11 = 10'b1010101011;

    localparam logic [WORD_W-1:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } align_state_t;

    typedef struct packed {
        logic              hit;
        logic [CTRL_W-1:0] ctrl;
    } ctrl_match_t;

    typedef struct packed {
        logic               hit;
        logic [TERC4_W-1:0] idx;
    } terc4_match_t;

    // Control-token recogniser; ctrl is {C1,C0}.
    function automatic ctrl_match_t ctrl_match(input logic [WORD_W-1:0] w);
        ctrl_match_t m;
        m.hit  = 1'b1;
        m.ctrl = 2'b00;
        case (w)
            CTRL_TOK_00: m.ctrl = 2'b00;
            CTRL_TOK_01: m.ctrl = 2'b01;
            CTRL_TOK_10: m.ctrl = 2'b10;
            CTRL_TOK_11: m.ctrl = 2'b11;
            default:     m.hit  = 1'b0;
        endcase
        return m;
    endfunction

    // TERC4 table lookup; idx is only meaningful when hit is set.
    function automatic terc4_match_t terc4_match(input logic [WORD_W-1:0] w);
        terc4_match_t m;
        m.hit = 1'b0;
        m.idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (w == TERC4_CODE[i]) begin
                m.hit = 1'b1;
                m.idx = TERC4_W'(i);
            end
        end
        return m;
    endfunction

    // Undo the DC-balance inversion, then the XOR/XNOR transition chain.
    function automatic logic [BYTE_W-1:0] video_decode(input logic [WORD_W-1:0] w);
        logic [BYTE_W-1:0] d;
        logic [BYTE_W-1:0] o;
        d    = w[9] ? ~w[7:0] : w[7:0];
        o    = '0;
        o[0] = d[0];
        for (int k = 1; k < 8; k++) begin
            o[k] = w[8] ? (d[k] ^ d[k-1]) : ~(d[k] ^ d[k-1]);
        end
        return o;
    endfunction

endpackage

// File: rtl/tmds_channel_dec.sv
// One TMDS channel: video/control/TERC4 decode plus the word-alignment FSM.
module tmds_channel_dec
    import tmds_pkg::*;
#(
    parameter int unsigned CTRL_RUN       = 8,
    parameter int unsigned SEARCH_TIMEOUT = 4096,
    parameter int unsigned SLIP_HOLD      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  datain_i,
    output logic [BYTE_W-1:0]  data_o,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic               de_o,
    output logic [TERC4_W-1:0] terc4_o,
    output logic               terc4_valid_o,
    output logic               bitslip_o,
    output logic               locked_o
);

    localparam int unsigned RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int unsigned TMR_W  = $clog2(SEARCH_TIMEOUT + 1);
    localparam int unsigned HOLD_W = $clog2(SLIP_HOLD + 1);

    ctrl_match_t        tok;
    terc4_match_t       terc;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [TMR_W-1:0]   timer_q;
    logic [HOLD_W-1:0]  hold_q;
    align_state_t       state_q;
    logic               qual, expire;

    logic [BYTE_W-1:0]  data_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic               de_q;
    logic [TERC4_W-1:0] terc4_q;
    logic               terc4_valid_q;
    logic               bitslip_q;
    logic               locked_q;

    assign tok    = ctrl_match(datain_i);
    assign terc   = terc4_match(datain_i);
    assign qual   = (run_d == RUN_W'(CTRL_RUN));
    assign expire = (timer_q == TMR_W'(SEARCH_TIMEOUT - 1));

    // Saturating control-token run length including the current word.
    always_comb begin
        run_d = '0;
        if (tok.hit) begin
            run_d = (run_q == RUN_W'(CTRL_RUN)) ? run_q : run_q + RUN_W'(1);
        end
    end

    // Word decode: tokens update ctrl, everything else is video; TERC4 in parallel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q        <= '0;
            ctrl_q        <= '0;
            de_q          <= 1'b0;
            terc4_q       <= '0;
            terc4_valid_q <= 1'b0;
        end else begin
            if (tok.hit) begin
                de_q   <= 1'b0;
                ctrl_q <= tok.ctrl;
            end else begin
                de_q   <= 1'b1;
                data_q <= video_decode(datain_i);
            end
            terc4_valid_q <= terc.hit;
            if (terc.hit) begin
                terc4_q <= terc.idx;
            end
        end
    end

    // Alignment FSM: a qualifying run beats timer expiry in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEARCH;
            run_q     <= '0;
            timer_q   <= '0;
            hold_q    <= '0;
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            bitslip_q <= 1'b0;
            unique case (state_q)
                SEARCH: begin
                    if (qual) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        run_q    <= run_d;
                        timer_q  <= '0;
                    end else if (expire) begin
                        state_q   <= SLIP_WAIT;
                        bitslip_q <= 1'b1;
                        run_q     <= '0;
                        timer_q   <= '0;
                        hold_q    <= '0;
                    end else begin
                        run_q   <= run_d;
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                SLIP_WAIT: begin
                    run_q   <= '0;
                    timer_q <= '0;
                    if (hold_q == HOLD_W'(SLIP_HOLD - 1)) begin
                        state_q <= SEARCH;
                        hold_q  <= '0;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                LOCKED: begin
                    if (qual) begin
                        run_q   <= run_d;
                        timer_q <= '0;
                    end else if (expire) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        run_q    <= '0;
                        timer_q  <= '0;
                    end else begin
                        run_q   <= run_d;
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    assign data_o        = data_q;
    assign ctrl_o        = ctrl_q;
    assign de_o          = de_q;
    assign terc4_o       = terc4_q;
    assign terc4_valid_o = terc4_valid_q;
    assign bitslip_o     = bitslip_q;
    assign locked_o      = locked_q;

endmodule

// File: rtl/tmds_decoder_multi.sv
// NCH parallel TMDS channel decoders with per-channel and aggregate lock.
module tmds_decoder_multi
    import tmds_pkg::*;
#(
    parameter int unsigned NCH            = 3,
    parameter int unsigned CTRL_RUN       = 8,
    parameter int unsigned SEARCH_TIMEOUT = 4096,
    parameter int unsigned SLIP_HOLD      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WORD_W-1:0]  datain,
    output logic [NCH*BYTE_W-1:0]  data_out,
    output logic [NCH*CTRL_W-1:0]  ctrl_out,
    output logic [NCH-1:0]         de_out,
    output logic [NCH*TERC4_W-1:0] terc4_out,
    output logic [NCH-1:0]         terc4_valid,
    output logic [NCH-1:0]         bitslip,
    output logic [NCH-1:0]         locked,
    output logic                   all_locked
);

    logic all_locked_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tmds_channel_dec #(
            .CTRL_RUN       (CTRL_RUN),
            .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
            .SLIP_HOLD      (SLIP_HOLD)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .datain_i      (datain[WORD_W*i +: WORD_W]),
            .data_o        (data_out[BYTE_W*i +: BYTE_W]),
            .ctrl_o        (ctrl_out[CTRL_W*i +: CTRL_W]),
            .de_o          (de_out[i]),
            .terc4_o       (terc4_out[TERC4_W*i +: TERC4_W]),
            .terc4_valid_o (terc4_valid[i]),
            .bitslip_o     (bitslip[i]),
            .locked_o      (locked[i])
        );
    end

    // Aggregate lock, one cycle behind the per-channel flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_locked_q <= 1'b0;
        end else begin
            all_locked_q <= &locked;
        end
    end

    assign all_locked = all_locked_q;

endmodule

// File: tb/tb_tmds_decoder_multi.sv
// Directed plus random checks of tmds_decoder_multi against a behavioural model.
module tb_tmds_decoder_multi;

    localparam int NCH  = 3;
    localparam int RUN  = 8;
    localparam int TMO  = 16;
    localparam int HOLD = 4;

    localparam int M_HUNT   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_LOCK   = 2;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK11 = 10'b1010101011;
    localparam logic [9:0] VID   = 10'b0111111111;
    localparam logic [9:0] T9    = 10'b0100111001;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*10-1:0] datain;
    logic [NCH*8-1:0]  data_out;
    logic [NCH*2-1:0]  ctrl_out;
    logic [NCH-1:0]    de_out;
    logic [NCH*4-1:0]  terc4_out;
    logic [NCH-1:0]    terc4_valid;
    logic [NCH-1:0]    bitslip;
    logic [NCH-1:0]    locked;
    logic              all_locked;

    int checks = 0;
    int errors = 0;
    logic [NCH-1:0] bs_seen;

    logic [9:0] tok_tab [4]  = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0] terc_tab[16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    // Model state and expected outputs per channel.
    int         m_mode  [NCH];
    int         m_run   [NCH];
    int         m_age   [NCH];
    int         m_settle[NCH];
    logic [7:0] e_data  [NCH];
    logic [1:0] e_ctrl  [NCH];
    logic [3:0] e_tout  [NCH];
    logic       e_de    [NCH];
    logic       e_tv    [NCH];
    logic       e_bs    [NCH];
    logic       e_lk    [NCH];
    logic       e_all;

    tmds_decoder_multi #(
        .NCH(NCH), .CTRL_RUN(RUN), .SEARCH_TIMEOUT(TMO), .SLIP_HOLD(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .datain(datain), .data_out(data_out),
        .ctrl_out(ctrl_out), .de_out(de_out), .terc4_out(terc4_out),
        .terc4_valid(terc4_valid), .bitslip(bitslip), .locked(locked),
        .all_locked(all_locked)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Video byte: un-invert, then each bit is the XOR of adjacent bits (XNOR when bit8=0).
    function automatic logic [7:0] video_ref(input logic [9:0] w);
        logic [7:0] d;
        d = w[9] ? ~w[7:0] : w[7:0];
        return d ^ (d << 1) ^ (w[8] ? 8'h00 : 8'hFE);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = M_HUNT; m_run[c] = 0; m_age[c] = 0; m_settle[c] = 0;
            e_data[c] = '0; e_ctrl[c] = '0; e_tout[c] = '0;
            e_de[c] = 1'b0; e_tv[c] = 1'b0; e_bs[c] = 1'b0; e_lk[c] = 1'b0;
        end
        e_all = 1'b0;
    endtask

    task automatic chan_step(input int c, input logic [9:0] w);
        int tk;
        int ti;
        tk = -1;
        ti = -1;
        for (int i = 0; i < 4; i++)  if (w == tok_tab[i])  tk = i;
        for (int i = 0; i < 16; i++) if (w == terc_tab[i]) ti = i;
        if (tk >= 0) begin
            e_de[c] = 1'b0; e_ctrl[c] = 2'(tk);
        end else begin
            e_de[c] = 1'b1; e_data[c] = video_ref(w);
        end
        if (ti >= 0) begin
            e_tv[c] = 1'b1; e_tout[c] = 4'(ti);
        end else begin
            e_tv[c] = 1'b0;
        end
        e_bs[c] = 1'b0;
        if (m_mode[c] == M_SETTLE) begin
            m_settle[c]--;
            if (m_settle[c] == 0) m_mode[c] = M_HUNT;
        end else begin
            m_run[c] = (tk >= 0) ? ((m_run[c] < RUN) ? m_run[c] + 1 : RUN) : 0;
            if (m_run[c] == RUN) begin
                m_age[c]  = 0;
                m_mode[c] = M_LOCK;
            end else if (m_age[c] == TMO - 1) begin
                m_age[c] = 0;
                m_run[c] = 0;
                if (m_mode[c] == M_HUNT) begin
                    e_bs[c]     = 1'b1;
                    m_mode[c]   = M_SETTLE;
                    m_settle[c] = HOLD;
                end else begin
                    m_mode[c] = M_HUNT;
                end
            end else begin
                m_age[c]++;
            end
        end
        e_lk[c] = (m_mode[c] == M_LOCK);
    endtask

    task automatic model_step(input logic [NCH*10-1:0] w);
        logic prev_all;
        prev_all = 1'b1;
        for (int c = 0; c < NCH; c++) prev_all = prev_all & e_lk[c];
        for (int c = 0; c < NCH; c++) chan_step(c, w[c*10 +: 10]);
        e_all = prev_all;
    endtask

    task automatic check_all();
        logic [NCH*8-1:0] ed;
        logic [NCH*2-1:0] ec;
        logic [NCH*4-1:0] et;
        logic [NCH-1:0]   ede, etv, ebs, elk;
        for (int c = 0; c < NCH; c++) begin
            ed[c*8 +: 8] = e_data[c];
            ec[c*2 +: 2] = e_ctrl[c];
            et[c*4 +: 4] = e_tout[c];
            ede[c] = e_de[c]; etv[c] = e_tv[c]; ebs[c] = e_bs[c]; elk[c] = e_lk[c];
        end
        check("data_out",    64'(data_out),    64'(ed));
        check("ctrl_out",    64'(ctrl_out),    64'(ec));
        check("de_out",      64'(de_out),      64'(ede));
        check("terc4_out",   64'(terc4_out),   64'(et));
        check("terc4_valid", 64'(terc4_valid), 64'(etv));
        check("bitslip",     64'(bitslip),     64'(ebs));
        check("locked",      64'(locked),      64'(elk));
        check("all_locked",  64'(all_locked),  64'(e_all));
    endtask

    // One clock: drive at negedge, model the posedge, compare at the next negedge.
    task automatic cycle(input logic [NCH*10-1:0] w);
        datain = w;
        @(posedge clk);
        model_step(w);
        @(negedge clk);
        check_all();
        bs_seen = bs_seen | bitslip;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"},   64'(data_out),    64'd0);
        check({tag, "_ctrl"},   64'(ctrl_out),    64'd0);
        check({tag, "_de"},     64'(de_out),      64'd0);
        check({tag, "_terc4"},  64'(terc4_out),   64'd0);
        check({tag, "_tvalid"}, 64'(terc4_valid), 64'd0);
        check({tag, "_bslip"},  64'(bitslip),     64'd0);
        check({tag, "_locked"}, 64'(locked),      64'd0);
        check({tag, "_all"},    64'(all_locked),  64'd0);
    endtask

    // Entered at a negedge; leaves at a negedge with rst released.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_zero(tag);
        @(posedge clk);
        @(negedge clk);
        check_zero({tag, "_held"});
        rst     = 1'b0;
        bs_seen = '0;
    endtask

    function automatic logic [9:0] rand_word();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 8)  return tok_tab[$urandom_range(0, 3)];
        if (r == 8) return terc_tab[$urandom_range(0, 15)];
        return 10'($urandom);
    endfunction

    initial begin
        logic [NCH*10-1:0] w;
        rst     = 1'b1;
        datain  = '0;
        bs_seen = '0;
        @(negedge clk);
        do_reset("reset");

        // Channel 0 locks on eight 00 tokens.
        for (int i = 0; i < 8; i++) begin
            cycle({VID, VID, TOK00});
            if (i == 0) begin
                check("A_de0_tok",   64'(de_out[0]),     64'd0);
                check("A_ctrl0_tok", 64'(ctrl_out[1:0]), 64'd0);
            end
            if (i == 6) check("A_lock_pre", 64'(locked[0]), 64'd0);
        end
        check("A_lock_post", 64'(locked[0]),  64'd1);
        check("A_no_slip",   64'(bs_seen[0]), 64'd0);

        // Video then a token on the locked channel.
        cycle({VID, VID, VID});
        check("B_data",  64'(data_out[7:0]), 64'h01);
        check("B_de",    64'(de_out[0]),     64'd1);
        cycle({VID, VID, TOK11});
        check("B_ctrl",  64'(ctrl_out[1:0]), 64'd3);
        check("B_de_tok", 64'(de_out[0]),    64'd0);
        check("B_hold",  64'(data_out[7:0]), 64'h01);

        // Re-qualify, then starve channel 0 of tokens until lock drops.
        for (int i = 0; i < 8; i++) cycle({VID, VID, TOK00});
        check("C_relock", 64'(locked[0]), 64'd1);
        bs_seen = '0;
        for (int i = 0; i < 16; i++) begin
            cycle({VID, VID, VID});
            if (i == 14) check("C_lock_hold", 64'(locked[0]), 64'd1);
        end
        check("C_lock_lost", 64'(locked[0]),  64'd0);
        check("C_no_slip",   64'(bs_seen[0]), 64'd0);

        // Constant video: slips at 15, 35, 55.
        do_reset("reset2");
        for (int n = 0; n < 60; n++) begin
            cycle({VID, VID, VID});
            check("D_bitslip", 64'(bitslip[0]), 64'((n == 15) || (n == 35) || (n == 55)));
            check("D_locked",  64'(locked[0]),  64'd0);
        end

        // TERC4 hit on channel 2, then a token leaves the nibble held.
        cycle({T9, VID, VID});
        check("E_tvalid",  64'(terc4_valid[2]),  64'd1);
        check("E_tout",    64'(terc4_out[11:8]), 64'h9);
        check("E_de",      64'(de_out[2]),       64'd1);
        cycle({TOK00, VID, VID});
        check("E_tvalid0", 64'(terc4_valid[2]),  64'd0);
        check("E_thold",   64'(terc4_out[11:8]), 64'h9);

        // Staggered locks at 9, 12, 14 (timeout of 16 bounds the latest start); all_locked at 15.
        do_reset("reset3");
        for (int n = 0; n < 19; n++) begin
            w[9:0]   = (n >= 2) ? TOK00 : VID;
            w[19:10] = (n >= 5) ? TOK11 : VID;
            w[29:20] = (n >= 7) ? TOK01 : VID;
            cycle(w);
            if (n == 8)  check("F_lock0_pre", 64'(locked[0]),  64'd0);
            if (n == 9)  check("F_lock0",     64'(locked[0]),  64'd1);
            if (n == 11) check("F_lock1_pre", 64'(locked[1]),  64'd0);
            if (n == 12) check("F_lock1",     64'(locked[1]),  64'd1);
            if (n == 13) check("F_lock2_pre", 64'(locked[2]),  64'd0);
            if (n == 14) check("F_all_pre",   64'(all_locked), 64'd0);
            if (n == 15) check("F_all",       64'(all_locked), 64'd1);
        end
        check("F_no_slip", 64'(bs_seen), 64'd0);

        // Asynchronous reset mid-operation.
        do_reset("midrst");
        cycle({VID, VID, VID});

        // Random mix of tokens, TERC4 codes and arbitrary words.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) w[c*10 +: 10] = rand_word();
            cycle(w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
